// File: rtl/regfile_write_port_if.sv
// Write-request handshake bundle for the register bank write port.
// The master issues {wr_sel, wr_data} under wr_valid; the slave answers with wr_ready.
interface regfile_write_port_if #(
  parameter int unsigned WIDTH = 16
);
  logic             wr_valid;
  logic             wr_ready;
  logic [2:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_sel,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_sel,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/regfile_write_port.sv
// Write side of the 8-entry register bank: an in-order request queue that commits
// one entry per cycle into the addressed register and exposes all registers as A..H.
module regfile_write_port #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  regfile_write_port_if.slave          wr,
  input  logic                         hold,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             A,
  output logic [WIDTH-1:0]             B,
  output logic [WIDTH-1:0]             C,
  output logic [WIDTH-1:0]             D,
  output logic [WIDTH-1:0]             E,
  output logic [WIDTH-1:0]             F,
  output logic [WIDTH-1:0]             G,
  output logic [WIDTH-1:0]             H
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]       sel_mem  [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] regs_q   [8];
  logic             push;
  logic             pop;
  logic [2:0]       head_sel;
  logic [WIDTH-1:0] head_data;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // Ready looks only at occupancy, so a same-cycle commit never frees a slot early.
  assign wr.wr_ready = (count_q < CW'(DEPTH)) & rst_n;
  assign push        = wr.wr_valid & wr.wr_ready;
  assign pop         = (count_q != '0) & ~hold;
  assign head_sel    = sel_mem[rd_ptr_q];
  assign head_data   = data_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (push) begin
        sel_mem[wr_ptr_q]  <= wr.wr_sel;
        data_mem[wr_ptr_q] <= wr.wr_data;
        wr_ptr_q           <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
        // Literal matching leaves every register untouched for an X/Z select.
        case (head_sel)
          3'b111:  regs_q[7] <= head_data;
          3'b110:  regs_q[6] <= head_data;
          3'b101:  regs_q[5] <= head_data;
          3'b100:  regs_q[4] <= head_data;
          3'b011:  regs_q[3] <= head_data;
          3'b010:  regs_q[2] <= head_data;
          3'b001:  regs_q[1] <= head_data;
          3'b000:  regs_q[0] <= head_data;
          default: ;
        endcase
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign busy  = (count_q != '0);
  assign count = count_q;
  assign A     = regs_q[7];
  assign B     = regs_q[6];
  assign C     = regs_q[5];
  assign D     = regs_q[4];
  assign E     = regs_q[3];
  assign F     = regs_q[2];
  assign G     = regs_q[1];
  assign H     = regs_q[0];
endmodule

// File: tb/tb_regfile_write_port.sv
// Bench for regfile_write_port: directed and random traffic against a queue-based
// reference; the monitor compares every register, count, busy and wr_ready each cycle.
module tb_regfile_write_port;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [2:0]       sel;
    logic [WIDTH-1:0] data;
  } ent_t;

  logic             clk;
  logic             rst_n;
  logic             hold;
  logic             busy;
  logic [1:0]       count;
  logic [WIDTH-1:0] A, B, C, D, E, F, G, H;
  logic [WIDTH-1:0] dut_regs [8];

  int               n_tests;
  int               n_fail;
  ent_t             mq [$];
  ent_t             e;
  logic [WIDTH-1:0] ref_regs [8];
  string            rname [8] = '{"H", "G", "F", "E", "D", "C", "B", "A"};

  regfile_write_port_if #(.WIDTH(WIDTH)) ifc ();

  regfile_write_port #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wr   (ifc),
    .hold (hold),
    .busy (busy),
    .count(count),
    .A    (A),
    .B    (B),
    .C    (C),
    .D    (D),
    .E    (E),
    .F    (F),
    .G    (G),
    .H    (H)
  );

  assign dut_regs[7] = A;
  assign dut_regs[6] = B;
  assign dut_regs[5] = C;
  assign dut_regs[4] = D;
  assign dut_regs[3] = E;
  assign dut_regs[2] = F;
  assign dut_regs[1] = G;
  assign dut_regs[0] = H;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a FIFO of accepted writes and an array indexed by select value.
  initial begin
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    end else begin
      bit can_take;
      can_take = (mq.size() < DEPTH);
      if (mq.size() != 0 && !hold) begin
        e = mq.pop_front();
        ref_regs[e.sel] = e.data;
      end
      if (ifc.wr_valid && can_take) begin
        mq.push_back('{sel: ifc.wr_sel, data: ifc.wr_data});
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      check(rname[i], 32'(dut_regs[i]), 32'(ref_regs[i]));
    end
    check("count", 32'(count), 32'(mq.size()));
    check("busy", 32'(busy), 32'(mq.size() != 0));
    check("wr_ready", 32'(ifc.wr_ready), 32'((mq.size() < DEPTH) && rst_n));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    ifc.wr_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Holds the request until the DUT accepts it; leaves wr_valid high for back-to-back use.
  task automatic send(input logic [2:0] s, input logic [WIDTH-1:0] d);
    bit r;
    int guard;
    ifc.wr_valid = 1'b1;
    ifc.wr_sel   = s;
    ifc.wr_data  = d;
    guard        = 0;
    forever begin
      @(negedge clk);
      r = ifc.wr_ready;
      tick();
      if (r) break;
      guard++;
      if (guard > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: sel %b data %h never accepted, expected within 50 cycles",
                 s, d);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    hold         = 1'b0;
    ifc.wr_valid = 1'b1;
    ifc.wr_sel   = 3'b111;
    ifc.wr_data  = 16'hFFFF;
    repeat (3) tick();
    rst_n = 1'b1;
    idle(2);

    // One write per register, back to back.
    for (int i = 0; i < 8; i++) send(3'(7 - i), 16'hA000 + 16'(i));
    idle(3);

    // Fill under hold, third request stalls until hold drops.
    hold = 1'b1;
    send(3'b010, 16'h1111);
    send(3'b010, 16'h2222);
    fork
      send(3'b010, 16'h3333);
      begin
        repeat (4) tick();
        hold = 1'b0;
      end
    join
    idle(4);

    send(3'b000, 16'hBEEF);
    send(3'b000, 16'hCAFE);
    idle(3);

    // Reset with queued entries discards them and clears committed values.
    send(3'b111, 16'h5A5A);
    idle(3);
    hold = 1'b1;
    send(3'b001, 16'h1234);
    send(3'b010, 16'h4321);
    idle(1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    hold  = 1'b0;
    idle(4);

    repeat (400) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      hold         = ($urandom_range(0, 3) == 0);
      ifc.wr_valid = ($urandom_range(0, 2) != 0);
      ifc.wr_sel   = 3'($urandom_range(0, 7));
      ifc.wr_data  = 16'($urandom);
      tick();
    end
    rst_n = 1'b1;
    hold  = 1'b0;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
